// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared types, funct3 codes and helpers for the RV32M sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int XLEN_ITER = 32;
    localparam int CNT_W     = $clog2(XLEN_ITER);

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
// muldiv_signfix : operand magnitude/sign extraction and final sign correction
// Revision       : 1.0
// ============================================================================
`default_nettype none

module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              sign_a,
    output logic              sign_b,
    input  logic [2:0]        op_funct3,
    input  logic              op_sign_a,
    input  logic              op_sign_b,
    input  logic              div_zero,
    input  logic [2*XLEN-1:0] raw,
    output logic [XLEN-1:0]   fixed
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        sign_a = a_is_signed(funct3) & op_a[XLEN-1];
        sign_b = b_is_signed(funct3) & op_b[XLEN-1];
        mag_a  = sign_a ? -op_a : op_a;
        mag_b  = sign_b ? -op_b : op_b;
    end

    // A zero divisor leaves the dividend magnitude in the remainder, so the
    // usual remainder correction rebuilds op_a; only the quotient is held.
    always_comb begin
        prod  = (op_sign_a ^ op_sign_b) ? -raw : raw;
        quo   = raw[XLEN-1:0];
        rem   = raw[2*XLEN-1:XLEN];
        fixed = '0;
        case (op_funct3)
            F3_MUL:                        fixed = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fixed = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:
                fixed = ((op_sign_a ^ op_sign_b) && !div_zero) ? -quo : quo;
            F3_REM, F3_REMU:               fixed = op_sign_a ? -rem : rem;
            default:                       fixed = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// muldiv_seq : iterative RV32M multiply/divide sequencer owning the EX stall.
//              MULDIV_FAST_EN: zero-operand multiplies and zero-divisor
//              divides bypass the iteration phase.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t     state;
    muldiv_state_t     state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        fn;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] work;
    logic [2*XLEN-1:0] work_next;

    logic              accept;
    logic              fast;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   fixed;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rsh;
    logic              ge;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   new_rem;

`ifdef MULDIV_FAST_EN
    logic [XLEN-1:0]   fast_result;

    always_comb begin
        fast        = is_div(funct3) ? (op_b == '0) : ((op_a == '0) || (op_b == '0));
        fast_result = '0;
        if (is_div(funct3))
            fast_result = funct3[1] ? op_a : '1;
    end
`else
    assign fast = 1'b0;
`endif

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .op_funct3 (fn),
        .op_sign_a (sa),
        .op_sign_b (sb),
        .div_zero  (opnd == '0),
        .raw       (work_next),
        .fixed     (fixed)
    );

    // work holds {hi, lo} of the product, or {remainder, quotient} for divides
    always_comb begin
        mul_sum = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
        rsh     = {work[2*XLEN-1:XLEN], work[XLEN-1]};
        ge      = rsh >= {1'b0, opnd};
        diff    = rsh[XLEN-1:0] - opnd;
        new_rem = ge ? diff : rsh[XLEN-1:0];
        if (is_div(fn))
            work_next = {new_rem, work[XLEN-2:0], ge};
        else
            work_next = {mul_sum, work[XLEN-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: if (cnt == '0) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush)
            state_next = ST_IDLE;
        stall = accept || (state == ST_CALC);
        busy  = (state == ST_CALC);
        done  = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            fn     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            opnd   <= '0;
            work   <= '0;
            result <= '0;
        end else if (accept) begin
            cnt  <= CNT_W'(XLEN_ITER - 1);
            fn   <= funct3;
            sa   <= sign_a;
            sb   <= sign_b;
            opnd <= mag_b;
            work <= {{XLEN{1'b0}}, mag_a};
`ifdef MULDIV_FAST_EN
            if (fast)
                result <= fast_result;
`endif
        end else if (state == ST_CALC && !flush) begin
            work <= work_next;
            if (cnt == '0)
                result <= fixed;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer for the EX stage. It accepts one M-extension operation from the decoder, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline via `stall` until the result is ready. The main ALU keeps handling every non-M operation. Only this block is multi-cycle, so it owns the EX-stage stall for M instructions.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: an M-instruction is in EX. Held high for as long as the instruction stays in EX.
- `funct3`, in, 3: M op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`, in, XLEN: rs1 value. Sampled only on the accept cycle.
- `op_b`, in, XLEN: rs2 value. Sampled only on the accept cycle.
- `flush`, in, 1: synchronous abort (branch/halt flush).
- `stall`, out, 1: freezes IF/ID/EX.
- `busy`, out, 1: state is CALC.
- `done`, out, 1: one-cycle pulse; `result` is valid.
- `result`, out, XLEN: registered result, held until the next accept.

## Operation
States: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 and `flush`=0 accepts the op.
  - On accept, the block latches `funct3`, the operand magnitudes and the sign flags, loads the iteration counter with 31, and moves to CALC.
- **CALC**
  - One iteration per cycle.
  - When the counter reaches 0, the block writes `result` (sign-corrected) and moves to DONE.
- **DONE**
  - `done`=1 and `stall`=0, so the pipeline advances this cycle.
  - `start` is ignored, because it still reflects the same instruction.
  - Next state is always IDLE.
- **flush**
  - Any state goes to IDLE on the next edge.
  - `done` is not pulsed and `result` is not updated.
  - `flush` wins over `start`.

Outputs:
- `stall` = (IDLE & `start` & !`flush`) | CALC. It is combinational, so the accept cycle already stalls.

Arithmetic:
- Signed operands are converted to magnitudes. MULHSU treats only `op_a` as signed.
- Multiply forms a 2·XLEN product.
  - MUL returns the low word.
  - MULH/MULHSU/MULHU return the high word.
  - The product is negated in 2·XLEN width when the operand signs differ.
- Divide produces an unsigned quotient and remainder.
  - Quotient sign = sign_a ^ sign_b. Remainder sign = sign_a.
- Divide by zero:
  - Quotient = all ones. Remainder = `op_a`.
  - Sign correction is suppressed.
- Overflow (−2^31 / −1) follows naturally: quotient 0x8000_0000, remainder 0.

Reset, asynchronous at any point including mid-CALC:
- State goes to IDLE and the counter to 0.
- `result`=0, `done`=0, `busy`=0.
- `stall` then follows IDLE logic.

## Timing
- Start is accepted at edge E0. CALC covers E1..E32. `done` is high in the cycle after E32, which is 33 cycles after acceptance, and `stall` is low in that same cycle.
- Back-to-back M instructions:
  - The second is accepted in the IDLE cycle right after DONE.
  - Minimum spacing is 34 cycles.
- `result` stays stable from DONE until the next accept edge.

## Configuration
- `MULDIV_FAST_EN` defined:
  - These ops skip CALC: DIV/DIVU/REM/REMU with `op_b`==0, and MUL* with `op_a`==0 or `op_b`==0.
  - They go IDLE→DONE at the accept edge, with `done` one cycle after acceptance.
  - Results are identical to the full-length path.
- `MULDIV_FAST_EN` undefined: every op takes the full 33-cycle path.

## Structure
- `muldiv_pkg` holds:
  - the state enum `muldiv_state_t` (IDLE/CALC/DONE);
  - `funct3` localparams (`F3_MUL` … `F3_REMU`);
  - `XLEN_ITER` = 32.
- One sub-module, `muldiv_signfix`, is combinational and does two jobs:
  - operand magnitude/sign extraction on the input side;
  - final negation and divide-by-zero suppression on the output side.
- The FSM, counter and shift registers stay in `muldiv_seq`.

## Test plan
- MUL 7 × −3: `result`=0xFFFF_FFEB, `done` exactly 33 cycles after accept, `stall` high for 33 cycles then low with `done`.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF: `result`=0xFFFF_FFFE. MULH −1 × −1: `result`=0. MULHSU −1 × 0xFFFF_FFFF: `result`=0xFFFF_FFFF.
- DIV −20 / 3: `result`=0xFFFF_FFFA (−6). REM −20 / 3: `result`=0xFFFF_FFFE (−2). DIV 0x8000_0000 / −1: `result`=0x8000_0000. REM 0x8000_0000 / −1: `result`=0.
- DIVU 5 / 0: `result`=0xFFFF_FFFF. REM −5 / 0: `result`=0xFFFF_FFFB. With `MULDIV_FAST_EN`, `done` comes 1 cycle after accept; without it, 33 cycles.
- `flush` asserted at CALC iteration 10: IDLE next cycle, no `done` pulse, `result` unchanged. A new DIVU 9/2 then yields 4.
- `reset` asserted mid-CALC: outputs go to 0 immediately. After release with `start` held, a fresh accept gives the correct result 33 cycles later.
